// File: rtl/mcu_subsys_sram_ctrl.sv
// Word SRAM on the PicoRV32 native bus: wait states, base-address window, optional parity (MCU_SUBSYS_SRAM_PARITY_EN).
// Latency: mem_ready is sampled high WAIT_STATES+3 edges after the edge that accepts mem_valid, counting that edge as the first.
// Backpressure: one request in flight; mem_valid is only sampled in IDLE and the latched copy of the request is used.
module mcu_subsys_sram_ctrl #(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        err_oob,
    output logic        parity_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [29:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [29:0]   word_off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          par_mismatch;
    logic          unused_addr_lsb;

    logic [31:0] mem [DEPTH_WORDS];

    assign unused_addr_lsb = ^mem_addr[1:0];

    // Word offset wraps modulo 2^30 words, so addresses below the base fall out of range.
    assign word_off = addr_q - BASE_ADDR[31:2];
    assign in_range = ~|word_off[29:AW];
    assign idx      = word_off[AW-1:0];

    always_ff @(posedge clk) begin
        if (state == S_ACCESS && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

`ifdef MCU_SUBSYS_SRAM_PARITY_EN
    logic [3:0] par_mem [DEPTH_WORDS];
    logic [3:0] rd_par;

    always_ff @(posedge clk) begin
        if (state == S_ACCESS && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) par_mem[idx][i] <= ^wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_par = '0;
        for (int i = 0; i < 4; i++) rd_par[i] = ^mem[idx][8*i +: 8];
    end

    assign par_mismatch = |(rd_par ^ par_mem[idx]);
`else
    assign par_mismatch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            mem_ready  <= 1'b0;
            err_oob    <= 1'b0;
            parity_err <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            mem_ready  <= 1'b0;
            err_oob    <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        addr_q   <= mem_addr[31:2];
                        wdata_q  <= mem_wdata;
                        wstrb_q  <= mem_wstrb;
                        wait_cnt <= '0;
                        state    <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'(WAIT_STATES - 1)) state <= S_ACCESS;
                    else wait_cnt <= wait_cnt + 4'd1;
                end
                S_ACCESS: begin
                    if (wstrb_q == 4'b0000) mem_rdata <= in_range ? mem[idx] : '0;
                    // Outputs are registered here so they are high exactly while in RESP.
                    mem_ready  <= 1'b1;
                    err_oob    <= ~in_range;
                    parity_err <= in_range && (wstrb_q == 4'b0000) && par_mismatch;
                    state      <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcu_subsys_sram_ctrl.sv
// Bench for mcu_subsys_sram_ctrl: a zero-wait instance at base 0 and a 3-wait instance at a high base.
module tb_mcu_subsys_sram_ctrl;
  localparam int          D0_DEPTH = 256;
  localparam logic [31:0] D0_BASE  = 32'h0000_0000;
  localparam int          D0_WS    = 0;
  localparam int          D1_DEPTH = 64;
  localparam logic [31:0] D1_BASE  = 32'h2000_0000;
  localparam int          D1_WS    = 3;

  logic        clk = 1'b0;
  logic        resetn [2];
  logic        valid  [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        ready  [2];
  logic [31:0] rdata  [2];
  logic        oob    [2];
  logic        perr   [2];

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rd [2];
  logic [31:0] model [D0_DEPTH];

  always #5 clk = ~clk;

  mcu_subsys_sram_ctrl #(.DEPTH_WORDS(D0_DEPTH), .BASE_ADDR(D0_BASE), .WAIT_STATES(D0_WS), .INIT_FILE("")) u_dut0 (
    .clk(clk), .resetn(resetn[0]), .mem_valid(valid[0]), .mem_ready(ready[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]), .err_oob(oob[0]), .parity_err(perr[0]));

  mcu_subsys_sram_ctrl #(.DEPTH_WORDS(D1_DEPTH), .BASE_ADDR(D1_BASE), .WAIT_STATES(D1_WS), .INIT_FILE("")) u_dut1 (
    .clk(clk), .resetn(resetn[1]), .mem_valid(valid[1]), .mem_ready(ready[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]), .err_oob(oob[1]), .parity_err(perr[1]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_oob;
  } vec_t;

  function automatic int ws_of(input int d);
    return (d == 0) ? D0_WS : D1_WS;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request at a negedge, scrambles the bus while busy, and reports the
  // index of the edge after which ready was first observed (-1 on timeout).
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd, output logic oo, output logic pe, output int lat);
    logic seen = 1'b0;
    rd = 'x; oo = 1'bx; pe = 1'bx; lat = -1;
    @(negedge clk);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = st;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        addr[d]  = $urandom;
        wdata[d] = $urandom;
      end
      if (ready[d]) begin
        seen = 1'b1; lat = k;
        rd = rdata[d]; oo = oob[d]; pe = perr[d];
        valid[d] = 1'b0;
      end
    end
    if (seen) begin
      @(posedge clk);
      @(negedge clk);
      check("ready_width", 32'(ready[d]), 32'd0);
    end
  endtask

  task automatic run(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input logic [31:0] exp_rd, input logic exp_oob, input logic exp_pe, input string name);
    logic [31:0] rd;
    logic oo, pe;
    int lat;
    txn(d, a, wd, st, rd, oo, pe, lat);
    // Ready is visible after edge WS+2 and sampled by the core on edge WS+3.
    check({name, "_lat"}, 32'(lat), 32'(ws_of(d) + 2));
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_oob"}, 32'(oo), 32'(exp_oob));
    check({name, "_perr"}, 32'(pe), 32'(exp_pe));
    last_rd[d] = exp_rd;
  endtask

  initial begin
    vec_t vt [15];
    logic [9:0] pat;
    logic seen_rdy;

    vt[0]  = '{32'h0000_0000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0};
    vt[1]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vt[2]  = '{32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    vt[3]  = '{32'h0000_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF, 1'b0};
    vt[4]  = '{32'h0000_0020, 32'h0000_00AA, 4'h1, 32'hDEAD_BEEF, 1'b0};
    vt[5]  = '{32'h0000_0020, 32'h0000_BB00, 4'h2, 32'hDEAD_BEEF, 1'b0};
    vt[6]  = '{32'h0000_0020, 32'h0000_0000, 4'h0, 32'h1122_BBAA, 1'b0};
    vt[7]  = '{32'h0000_0400, 32'hCAFE_F00D, 4'hF, 32'h1122_BBAA, 1'b1};
    vt[8]  = '{32'h0000_0000, 32'h0000_0000, 4'h0, 32'h1234_5678, 1'b0};
    vt[9]  = '{32'h0000_0400, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vt[10] = '{32'h0000_0020, 32'hAABB_CCDD, 4'hC, 32'h0000_0000, 1'b0};
    vt[11] = '{32'h0000_0023, 32'h0000_0000, 4'h0, 32'hAABB_BBAA, 1'b0};
    vt[12] = '{32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    vt[13] = '{32'h0000_03FC, 32'h0F0F_0F0F, 4'hF, 32'h0000_0000, 1'b0};
    vt[14] = '{32'h0000_03FC, 32'h0000_0000, 4'h0, 32'h0F0F_0F0F, 1'b0};

    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b0; valid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(ready[d]), 32'd0);
      check($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
      check($sformatf("rst_oob%0d", d), 32'(oob[d]), 32'd0);
      check($sformatf("rst_perr%0d", d), 32'(perr[d]), 32'd0);
      resetn[d] = 1'b1;
    end

    for (int i = 0; i < 15; i++)
      run(0, vt[i].a, vt[i].wd, vt[i].st, vt[i].exp_rd, vt[i].exp_oob, 1'b0, $sformatf("vec%0d", i));

    // Parity corner: corrupt one stored data bit behind the controller's back.
    run(0, 32'h0000_0080, 32'h0000_00FF, 4'hF, last_rd[0], 1'b0, 1'b0, "par_wr");
`ifdef MCU_SUBSYS_SRAM_PARITY_EN
    u_dut0.mem[32] = u_dut0.mem[32] ^ 32'h1;
    run(0, 32'h0000_0080, 32'h0, 4'h0, 32'h0000_00FE, 1'b0, 1'b1, "par_rd");
`else
    run(0, 32'h0000_0080, 32'h0, 4'h0, 32'h0000_00FF, 1'b0, 1'b0, "par_rd");
`endif

    // Randomised traffic against a word-array model over indices 64..95.
    for (int w = 64; w < 96; w++) begin
      model[w] = $urandom;
      run(0, D0_BASE + 32'(w * 4), model[w], 4'hF, last_rd[0], 1'b0, 1'b0, $sformatf("fill%0d", w));
    end
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, wd, exp_rd, widx;
      logic [3:0] st;
      logic exp_oob;
      if ($urandom_range(0, 9) == 0) a = 32'h0000_0400 + ($urandom % 32'hFFFF_F000);
      else a = D0_BASE + 32'(($urandom_range(64, 95) * 4) + $urandom_range(0, 3));
      st = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      widx = (a - D0_BASE) >> 2;
      exp_oob = (widx >= D0_DEPTH);
      if (exp_oob) exp_rd = (st == 4'h0) ? 32'h0 : last_rd[0];
      else if (st == 4'h0) exp_rd = model[widx];
      else begin
        exp_rd = last_rd[0];
        for (int b = 0; b < 4; b++) if (st[b]) model[widx][8*b +: 8] = wd[8*b +: 8];
      end
      run(0, a, wd, st, exp_rd, exp_oob, 1'b0, $sformatf("rnd%0d", n));
    end

    // Wait-state instance: prepare word, then held-valid read pattern.
    run(1, D1_BASE + 32'h40, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 1'b0, "ws_wr");
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = D1_BASE + 32'h40; wstrb[1] = 4'h0;
    pat = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      pat[k-1] = ready[1];
      if (k == 5) check("ws_hold_rdata", rdata[1], 32'h1111_1111);
    end
    check("ws_hold_pattern", 32'(pat), 32'h0000_0010);
    valid[1] = 1'b0;
    repeat (8) @(negedge clk);
    last_rd[1] = 32'h1111_1111;

    run(1, D1_BASE + 32'(D1_DEPTH * 4), 32'hCAFE_F00D, 4'hF, 32'h1111_1111, 1'b1, 1'b0, "ws_oob_wr");
    run(1, D1_BASE - 32'd4, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, "ws_below_base");

    // Reset lands while the write sits in WAIT: it must vanish without a trace.
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = D1_BASE + 32'h40; wdata[1] = 32'h5555_5555; wstrb[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    resetn[1] = 1'b0; valid[1] = 1'b0;
    seen_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ready[1]) seen_rdy = 1'b1;
    end
    check("rst_mid_noready", 32'(seen_rdy), 32'd0);
    check("rst_mid_rdata", rdata[1], 32'h0);
    last_rd[1] = 32'h0;
    run(1, D1_BASE + 32'h40, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 1'b0, "rst_mid_keep");
    run(1, D1_BASE, 32'hA5A5_0000, 4'hF, 32'h1111_1111, 1'b0, 1'b0, "ws_base_wr");
    run(1, D1_BASE + 32'h2, 32'h0, 4'h0, 32'hA5A5_0000, 1'b0, 1'b0, "ws_base_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
